button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//   N-channel conditioner for the board pushbuttons. Per channel: 2-flop synchronizer,
//   counter debounce, single-cycle press/release pulses, long-press pulse and optional
//   hold-to-repeat. Replaces the per-key debounce instances and hand-written edge
//   detectors in the game top level; drives move_left/move_right/move_made/reset strobes.
// PARAMETERS
//   N_BTN         4          number of independent channels
//   ACTIVE_LOW    1          1: btn_in low = pressed (DE1 KEY); 0: high = pressed
//   DB_CYCLES     250000     consecutive stable cycles to accept a level change (>=2)
//   LONG_CYCLES   25000000   cycles held (after btn_level rises) before long_pulse
//   REPEAT_DELAY  12500000   cycles held before first auto-repeat press_pulse
//   REPEAT_PERIOD 2500000    cycles between subsequent auto-repeat pulses (>=1)
// PORTS
//   clk            in   1      system clock (25 MHz VGA_CLK domain)
//   rst_n          in   1      asynchronous active-low reset
//   btn_in         in   N_BTN  raw asynchronous button inputs
//   repeat_mask    in   N_BTN  per-channel auto-repeat enable (ignored without macro)
//   btn_level      out  N_BTN  debounced level, 1 = pressed
//   press_pulse    out  N_BTN  1-cycle strobe: debounced press or auto-repeat tick
//   release_pulse  out  N_BTN  1-cycle strobe: debounced release
//   long_pulse     out  N_BTN  1-cycle strobe once per press after LONG_CYCLES held
// BEHAVIOUR
//   - Reset (rst_n=0, async): sync flops, stable levels, all counters cleared to the
//     released state; every output 0. Deassertion is used as-is (caller synchronizes).
//   - Input normalized: p = ACTIVE_LOW ? ~btn_in : btn_in, then 2-flop sync -> s.
//   - Debounce: cnt clears whenever s == btn_level; increments while s != btn_level;
//     on the cycle cnt == DB_CYCLES-1 with mismatch, btn_level <= s and cnt <= 0.
//     Clean step on btn_in -> btn_level changes exactly DB_CYCLES+2 edges later.
//     Glitch/bounce shorter than DB_CYCLES cycles: no output activity.
//   - press_pulse / release_pulse registered on the same edge btn_level rises / falls;
//     never both high; exactly one of each per accepted transition.
//   - Per-channel FSM: RELEASED -> (level rises) HELD_DELAY -> (held REPEAT_DELAY
//     cycles, repeat active) HELD_REPEAT -> every REPEAT_PERIOD cycles re-pulse.
//     Any state -> RELEASED on level fall (release_pulse, timers cleared).
//   - hold_cnt counts from 0 at the rising edge of btn_level, saturates at
//     max(LONG_CYCLES, REPEAT_DELAY); long_pulse fires at hold_cnt == LONG_CYCLES-1,
//     once per press; re-arms only after release.
//   - Counter widths $clog2(param+1); no wrap: saturation prevents re-triggering.
//   - Channels fully independent; simultaneous presses give simultaneous pulses.
//   - Reset mid-press: outputs drop to 0; a still-held button is re-accepted as a new
//     press (press_pulse) DB_CYCLES+2 edges after rst_n rises.
//   - repeat_mask sampled every cycle; clearing it in HELD_REPEAT stops pulses
//     immediately, FSM stays held until release.
// CONFIGURATION
//   BTN_AUTO_REPEAT_EN defined: HELD_DELAY/HELD_REPEAT logic and repeat counters built;
//     channels with repeat_mask=1 auto-repeat as above.
//   Not defined: repeat logic omitted, repeat_mask unused, press_pulse only on the
//     debounced press edge; all other behaviour identical.
// TESTING  (DB_CYCLES=4, LONG_CYCLES=20, REPEAT_DELAY=10, REPEAT_PERIOD=5, ACTIVE_LOW=1)
//   - Reset: rst_n=0 mid-cycle, btn_in=4'hF -> all outputs 0 asynchronously, stay 0.
//   - Clean press ch0 (btn_in[0] 1->0 held) -> btn_level[0]=1 and 1-cycle
//     press_pulse[0] exactly 6 edges later; release -> release_pulse[0] 6 edges later.
//   - Bounce: btn_in[1] low 3 cycles, high 1, low 3, high -> no output changes on ch1.
//   - Long press ch2 held 40 cycles -> one press_pulse, one long_pulse 20 cycles after
//     btn_level rise, no second long_pulse; release -> one release_pulse.
//   - Auto-repeat (macro on, repeat_mask[3]=1) ch3 held 30 cycles after accept ->
//     press_pulse at hold offsets 0,10,15,20,25; macro off -> only offset 0.
//   - Reset mid-press ch0 held: rst_n pulsed low -> outputs 0, then press_pulse[0]
//     again 6 edges after rst_n rises; ch1..3 idle throughout.

Source files
------------

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - port bundle for the N-channel pushbutton conditioner
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] repeat_mask;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic [N_BTN-1:0] long_pulse;

  modport master (
    output btn_in, repeat_mask,
    input  btn_level, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn_in, repeat_mask,
    output btn_level, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel sync, debounce, press/release/long strobes
// Optional hold-to-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int N_BTN         = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int DB_CYCLES     = 250000,
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);
  localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_W    = $clog2(REPEAT_PERIOD + 1);
`else
  localparam int repeat_period_unused = REPEAT_PERIOD;
  logic repeat_mask_unused;
  assign repeat_mask_unused = ^bus.repeat_mask;
`endif

  typedef enum logic [1:0] {RELEASED, HELD_DELAY, HELD_REPEAT} state_e;

  logic [N_BTN-1:0] p;
  logic [N_BTN-1:0] level_v, press_v, release_v, long_v;

  assign p = (ACTIVE_LOW != 0) ? ~bus.btn_in : bus.btn_in;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic              sync1_q, sync1_d, s_q, s_d, level_q, level_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    state_e            state_q, state_d;
    logic              press_q, press_d, release_q, release_d, long_q, long_d;
    logic              rise, fall;
`ifdef BTN_AUTO_REPEAT_EN
    logic [REP_W-1:0]  rep_q, rep_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        s_q       <= 1'b0;
        level_q   <= 1'b0;
        cnt_q     <= '0;
        hold_q    <= '0;
        state_q   <= RELEASED;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_q     <= '0;
`endif
      end else begin
        sync1_q   <= sync1_d;
        s_q       <= s_d;
        level_q   <= level_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        state_q   <= state_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
        rep_q     <= rep_d;
`endif
      end
    end

    // Level is accepted on the edge where the mismatch count reaches DB_CYCLES-1,
    // so a clean step shows up DB_CYCLES+2 edges after the raw input moves.
    always_comb begin
      sync1_d = p[i];
      s_d     = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (s_q != level_q) begin
        if (cnt_q == DB_W'(DB_CYCLES - 1)) level_d = s_q;
        else                               cnt_d   = cnt_q + 1'b1;
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
      hold_d  = hold_q;
      state_d = state_q;
      if (!level_d || rise)                     hold_d = '0;
      else if (hold_q != HOLD_W'(HOLD_MAX))     hold_d = hold_q + 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      rep_d = '0;
      if (state_q == HELD_REPEAT && !fall)
        rep_d = (rep_q == REP_W'(REPEAT_PERIOD - 1)) ? '0 : rep_q + 1'b1;
`endif
      case (state_q)
        RELEASED:    if (rise) state_d = HELD_DELAY;
        HELD_DELAY: begin
          if (fall) state_d = RELEASED;
`ifdef BTN_AUTO_REPEAT_EN
          else if (bus.repeat_mask[i] && hold_q == HOLD_W'(REPEAT_DELAY - 1))
            state_d = HELD_REPEAT;
`endif
        end
        HELD_REPEAT: if (fall) state_d = RELEASED;
        default:     state_d = RELEASED;
      endcase
    end

    always_comb begin
      press_d   = rise;
      release_d = fall;
      long_d    = level_q & level_d & (hold_q == HOLD_W'(LONG_CYCLES - 1));
`ifdef BTN_AUTO_REPEAT_EN
      // Mask is live every cycle: clearing it silences repeats without leaving the held state.
      if (!fall && bus.repeat_mask[i]) begin
        if (state_q == HELD_DELAY && hold_q == HOLD_W'(REPEAT_DELAY - 1)) press_d = 1'b1;
        if (state_q == HELD_REPEAT && rep_q == REP_W'(REPEAT_PERIOD - 1))  press_d = 1'b1;
      end
`endif
    end

    assign level_v[i]   = level_q;
    assign press_v[i]   = press_q;
    assign release_v[i] = release_q;
    assign long_v[i]    = long_q;
  end

  assign bus.btn_level     = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.long_pulse    = long_v;
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  int   press_cnt, long_cnt, rel_cnt, long_edge, rel_edge, other_act;
  int   press_edge [8];
  int   exp_rep [5];
  int   exp_rep_n;
  logic bounce [15];

  button_conditioner_if #(.N_BTN(N)) bus ();

  button_conditioner #(
    .N_BTN(N), .ACTIVE_LOW(1), .DB_CYCLES(4), .LONG_CYCLES(20),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.btn_level, bus.press_pulse, bus.release_pulse, bus.long_pulse};
  endfunction

  // Hold channel ch from now, let go after edge rel_after, record strobe edges.
  task automatic run_hold(input int ch, input int rel_after, input int n_edges);
    logic [3:0]  m;
    logic [15:0] chm;
    m   = 4'b0001 << ch;
    chm = {m, m, m, m};
    press_cnt = 0; long_cnt = 0; rel_cnt = 0;
    long_edge = -1; rel_edge = -1; other_act = 0;
    for (int k = 0; k < 8; k++) press_edge[k] = -1;
    bus.btn_in[ch] = 1'b0;
    for (int e = 1; e <= n_edges; e++) begin
      tick();
      if (bus.press_pulse[ch]) begin
        if (press_cnt < 8) press_edge[press_cnt] = e;
        press_cnt++;
      end
      if (bus.long_pulse[ch])    begin long_cnt++; long_edge = e; end
      if (bus.release_pulse[ch]) begin rel_cnt++;  rel_edge  = e; end
      if ((outs() & ~chm) != 16'h0) other_act++;
      if (e == rel_after) bus.btn_in[ch] = 1'b1;
    end
  endtask

  initial begin
    bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef BTN_AUTO_REPEAT_EN
    exp_rep   = '{6, 16, 21, 26, 31};
    exp_rep_n = 5;
`else
    exp_rep   = '{6, -1, -1, -1, -1};
    exp_rep_n = 1;
`endif

    bus.btn_in      = 4'hF;
    bus.repeat_mask = 4'h0;
    rst_n           = 1'b1;

    // asynchronous reset asserted mid-cycle
    #12;
    rst_n = 1'b0;
    #1;
    check("reset_async", outs(), 16'h0);
    repeat (3) tick();
    check("reset_hold", outs(), 16'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_after_reset", outs(), 16'h0);

    // clean press / release on ch0
    bus.btn_in[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("press0_e%0d", e), outs(),
            (e == 6) ? 16'h1100 : (e == 7) ? 16'h1000 : 16'h0000);
    end
    bus.btn_in[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("release0_e%0d", e), outs(),
            (e < 6) ? 16'h1000 : (e == 6) ? 16'h0010 : 16'h0000);
    end

    // bounce on ch1 never long enough to be accepted
    for (int i = 0; i < 15; i++) begin
      bus.btn_in[1] = bounce[i];
      tick();
      check($sformatf("bounce1_%0d", i), outs(), 16'h0);
    end

    // long press on ch2
    run_hold(2, 40, 60);
    check("long2_press_cnt", press_cnt, 1);
    check("long2_press_edge", press_edge[0], 6);
    check("long2_long_cnt", long_cnt, 1);
    check("long2_long_edge", long_edge, 26);
    check("long2_rel_cnt", rel_cnt, 1);
    check("long2_rel_edge", rel_edge, 46);
    check("long2_other", other_act, 0);

    // hold-to-repeat on ch3 (single press without the repeat build)
    bus.repeat_mask = 4'b1000;
    run_hold(3, 30, 45);
    check("rep3_press_cnt", press_cnt, exp_rep_n);
    for (int k = 0; k < exp_rep_n; k++)
      check($sformatf("rep3_press_edge%0d", k), press_edge[k], exp_rep[k]);
    check("rep3_long_cnt", long_cnt, 1);
    check("rep3_long_edge", long_edge, 26);
    check("rep3_rel_cnt", rel_cnt, 1);
    check("rep3_rel_edge", rel_edge, 36);
    check("rep3_other", other_act, 0);
    bus.repeat_mask = 4'h0;

    // reset while ch0 is held, then re-acceptance
    bus.btn_in[0] = 1'b0;
    repeat (10) tick();
    check("rst_mid_held", outs(), 16'h1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", outs(), 16'h0);
    repeat (2) tick();
    check("rst_mid_hold", outs(), 16'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rst_repress_e%0d", e), outs(),
            (e == 6) ? 16'h1100 : (e == 7) ? 16'h1000 : 16'h0000);
    end
    bus.btn_in[0] = 1'b1;
    repeat (10) tick();
    check("final_idle", outs(), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
